bsg_serializer: RTL and testbench
=================================

BSG_SERIALIZER -- requirements
Module: bsg_serializer

Interface
REQ-001 The block SHALL have parameter DATA_WIDTH, default 8: width of the control, data and status words; legal only when at least 8.
REQ-002 The block SHALL have one clock; reset is synchronous and active-high.
REQ-003 Port SYS_CLK, input, 1 bit: the single clock; every flop updates on its rising edge.
REQ-004 Port rst, input, 1 bit: synchronous reset, active-high.
REQ-005 Port ctrl_in, input, DATA_WIDTH bits: BSG_CONTROL register value.
- bit0: start.
- bit1: mode. 0 = 8-bit frame; 1 = 16-bit frame.
- bits7:4: div, the bit-period divider.
- bits 3:2 and DATA_WIDTH-1:8: ignored.
REQ-006 Port data0_in, input, DATA_WIDTH bits: BSG_DATA_0 value; sent first.
REQ-007 Port data1_in, input, DATA_WIDTH bits: BSG_DATA_1 value; sent second, in mode 1 only.
REQ-008 Port ser_out, output, 1 bit: serial data, MSB first.
REQ-009 Port ser_valid, output, 1 bit: high while ser_out carries a frame bit.
REQ-010 Port status_out, output, DATA_WIDTH bits: status word for the register block.
- bit2 = busy.
- bit3 = done.
- all other bits 0.

Function
REQ-011 The block SHALL implement a four-state FSM: IDLE, LOAD, SHIFT, DONE.
REQ-012 The block SHALL register ctrl_in[0] into start_q every cycle; a start event is ctrl_in[0]=1 with start_q=0.
REQ-013 On a start event in IDLE or DONE, the block SHALL enter LOAD on the next edge.
REQ-014 The block SHALL ignore start events while in LOAD or SHIFT.
REQ-015 On the edge leaving LOAD, the block SHALL enter SHIFT and capture the following.
- Shift register: {data0_in[7:0], data1_in[7:0]} in mode 1; data0_in[7:0] in the upper byte in mode 0.
- bit_cnt: 15 in mode 1; 7 in mode 0.
- div_cnt: div.
- The captured mode.
REQ-016 In SHIFT, the block SHALL drive ser_out = shift-register MSB and ser_valid = 1.
REQ-017 In SHIFT, each bit SHALL be held exactly div+1 cycles; div=0 gives one cycle per bit.
REQ-018 In SHIFT with div_cnt > 0, the block SHALL decrement div_cnt.
REQ-019 In SHIFT with div_cnt = 0 and bit_cnt > 0, the block SHALL:
- shift left by one;
- decrement bit_cnt;
- reload div_cnt = captured div.
REQ-020 In SHIFT with div_cnt = 0 and bit_cnt = 0, the block SHALL enter DONE on the next edge.
REQ-021 Frame length SHALL be (div+1)×8 cycles in mode 0 and (div+1)×16 cycles in mode 1, with ser_valid continuously high.
REQ-022 Changes to ctrl_in or data inputs after LOAD SHALL NOT affect the frame in progress.
REQ-023 busy SHALL be 1 in LOAD and SHIFT, and 0 otherwise.
REQ-024 done SHALL be 1 in DONE only, and SHALL clear on the edge that enters LOAD.
REQ-025 Outside SHIFT, ser_out and ser_valid SHALL be 0.
REQ-026 The block SHALL hold DONE indefinitely until a start event.
REQ-027 If start stays high across frames, the block SHALL send no further frame; a new frame needs 0 then 1 on ctrl_in[0].
REQ-028 A start event on the same edge that SHIFT enters DONE SHALL be ignored.
REQ-029 All outputs SHALL be registered or decoded from registered state only; there is no combinational path from inputs to outputs.

Reset
REQ-030 With rst=1 at a clock edge, the block SHALL force:
- FSM = IDLE;
- start_q = 0;
- shift register, bit_cnt and div_cnt = 0;
- ser_out = 0, ser_valid = 0, status_out = 0.
REQ-031 Reset SHALL take priority over every other event, including a reset mid-frame; the partial frame is discarded without entering DONE.
REQ-032 If ctrl_in[0] is held at 1 through reset release, the block SHALL treat it as a start event on the first edge after release.

Verification
REQ-033 Mode 0 bit order: ctrl_in 0x00→0x01, div=0, data0=0xA5. Required response:
- busy=1 for 1 cycle (LOAD);
- ser_out = 1,0,1,0,0,1,0,1 over 8 cycles with ser_valid=1;
- then status_out = 0x08.
REQ-034 Mode 1 divider: ctrl_in → 0x13 (div=1, mode=1), data0=0x3C, data1=0x81. Required response:
- 32 valid cycles, each bit doubled;
- sequence 00111100 10000001;
- then done=1.
REQ-035 Hold and re-arm: hold ctrl_in[0]=1 after a frame completes → no second frame, done stays 1; drop to 0 then 1 → new frame, done clears on entry to LOAD.
REQ-036 Mid-frame changes: start pulse and data0 change during SHIFT → transmitted bits equal the originally captured data, and frame length is unchanged.
REQ-037 Reset mid-frame: assert rst during the 4th bit → next cycle status_out=0x00, ser_valid=0, and done never asserts.
REQ-038 Maximum divider: div=15, mode 0 → each bit held 16 cycles, frame length 128 cycles.

Source files
------------

// File: rtl/bsg_serializer.sv
// bsg_serializer: register-driven 8/16-bit MSB-first serializer with bit-period divider
module bsg_serializer #(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  SYS_CLK,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] ctrl_in,
  input  logic [DATA_WIDTH-1:0] data0_in,
  input  logic [DATA_WIDTH-1:0] data1_in,
  output logic                  ser_out,
  output logic                  ser_valid,
  output logic [DATA_WIDTH-1:0] status_out
);
  typedef enum logic [1:0] {IDLE, LOAD, SHIFT, DONE} state_t;
  state_t      state;
  logic        start_q;
  logic [15:0] sreg;
  logic [3:0]  bit_cnt;
  logic [3:0]  div_cnt;
  logic [3:0]  div_q;
  logic        start_ev;
  logic        unused_ok;
  assign start_ev   = ctrl_in[0] & ~start_q;
  assign unused_ok  = ^{ctrl_in, data0_in, data1_in};
  assign ser_valid  = state == SHIFT;
  assign ser_out    = state == SHIFT && sreg[15];
  assign status_out = {{(DATA_WIDTH-4){1'b0}}, state == DONE, state == LOAD || state == SHIFT, 2'b00};
  always_ff @(posedge SYS_CLK) begin
    if (rst) begin
      state   <= IDLE;
      start_q <= 1'b0;
      sreg    <= '0;
      bit_cnt <= '0;
      div_cnt <= '0;
      div_q   <= '0;
    end else begin
      start_q <= ctrl_in[0];
      case (state)
        IDLE, DONE: state <= start_ev ? LOAD : state;
        LOAD: begin
          state   <= SHIFT;
          sreg    <= {data0_in[7:0], ctrl_in[1] ? data1_in[7:0] : 8'h00};
          bit_cnt <= ctrl_in[1] ? 4'd15 : 4'd7;
          div_cnt <= ctrl_in[7:4];
          div_q   <= ctrl_in[7:4];
        end
        default: begin
          if (div_cnt != 4'd0) begin
            div_cnt <= div_cnt - 4'd1;
          end else if (bit_cnt != 4'd0) begin
            sreg    <= {sreg[14:0], 1'b0};
            bit_cnt <= bit_cnt - 4'd1;
            div_cnt <= div_q;
          end else begin
            state <= DONE;
          end
        end
      endcase
    end
  end
endmodule

// File: tb/tb_bsg_serializer.sv
// tb_bsg_serializer: directed self-checking bench for bsg_serializer
module tb_bsg_serializer;
  logic       SYS_CLK;
  logic       rst;
  logic [7:0] ctrl_in;
  logic [7:0] data0_in;
  logic [7:0] data1_in;
  logic       ser_out;
  logic       ser_valid;
  logic [7:0] status_out;
  int vectors;
  int miscompares;
  bsg_serializer #(.DATA_WIDTH(8)) dut (
    .SYS_CLK(SYS_CLK),
    .rst(rst),
    .ctrl_in(ctrl_in),
    .data0_in(data0_in),
    .data1_in(data1_in),
    .ser_out(ser_out),
    .ser_valid(ser_valid),
    .status_out(status_out)
  );
  initial SYS_CLK = 1'b0;
  always #5 SYS_CLK = ~SYS_CLK;
  task automatic tick;
    @(posedge SYS_CLK);
    #1;
  endtask
  task automatic test_reset;
    rst = 1'b1; ctrl_in = 8'h00; data0_in = 8'h00; data1_in = 8'h00;
    tick(); tick();
    vectors++;
    if ({status_out, ser_valid, ser_out} !== 10'h000) begin
      miscompares++;
      $display("FAIL reset_outputs: got status=%h valid=%b out=%b want status=00 valid=0 out=0", status_out, ser_valid, ser_out);
    end
    rst = 1'b0;
    tick();
  endtask
  task automatic test_mode0;
    logic [7:0] exp_d;
    exp_d = 8'hA5;
    ctrl_in = 8'h00; tick();
    ctrl_in = 8'h01; data0_in = exp_d; data1_in = 8'hFF;
    tick();
    vectors++;
    if (status_out !== 8'h04 || ser_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL mode0_load: got status=%h valid=%b want status=04 valid=0", status_out, ser_valid);
    end
    tick();
    for (int i = 0; i < 8; i++) begin
      vectors++;
      if ({ser_valid, ser_out} !== {1'b1, exp_d[7-i]}) begin
        miscompares++;
        $display("FAIL mode0_bit%0d: got valid/out=%b%b want 1%b", i, ser_valid, ser_out, exp_d[7-i]);
      end
      tick();
    end
    vectors++;
    if (status_out !== 8'h08 || ser_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL mode0_done: got status=%h valid=%b want status=08 valid=0", status_out, ser_valid);
    end
  endtask
  task automatic test_mode1_div;
    logic [15:0] exp_d;
    exp_d = 16'h3C81;
    ctrl_in = 8'h00; tick();
    ctrl_in = 8'h13; data0_in = 8'h3C; data1_in = 8'h81;
    tick();
    vectors++;
    if (status_out !== 8'h04) begin
      miscompares++;
      $display("FAIL mode1_load_done_clear: got status=%h want 04", status_out);
    end
    tick();
    for (int i = 0; i < 32; i++) begin
      vectors++;
      if ({ser_valid, ser_out} !== {1'b1, exp_d[15-i/2]}) begin
        miscompares++;
        $display("FAIL mode1_cycle%0d: got valid/out=%b%b want 1%b", i, ser_valid, ser_out, exp_d[15-i/2]);
      end
      tick();
    end
    vectors++;
    if (status_out !== 8'h08 || ser_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL mode1_done: got status=%h valid=%b want status=08 valid=0", status_out, ser_valid);
    end
  endtask
  task automatic test_hold_rearm;
    logic [7:0] exp_d;
    int seen_valid;
    exp_d = 8'h5A;
    seen_valid = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      seen_valid += int'(ser_valid) + int'(status_out[2]);
    end
    vectors++;
    if (seen_valid != 0 || status_out !== 8'h08) begin
      miscompares++;
      $display("FAIL hold_no_refire: got busy/valid cycles=%0d status=%h want 0 and 08", seen_valid, status_out);
    end
    ctrl_in = 8'h12; tick();
    vectors++;
    if (status_out !== 8'h08) begin
      miscompares++;
      $display("FAIL hold_drop_keeps_done: got status=%h want 08", status_out);
    end
    ctrl_in = 8'h01; data0_in = exp_d;
    tick();
    vectors++;
    if (status_out !== 8'h04) begin
      miscompares++;
      $display("FAIL rearm_load: got status=%h want 04", status_out);
    end
    tick();
    for (int i = 0; i < 8; i++) begin
      vectors++;
      if ({ser_valid, ser_out} !== {1'b1, exp_d[7-i]}) begin
        miscompares++;
        $display("FAIL rearm_bit%0d: got valid/out=%b%b want 1%b", i, ser_valid, ser_out, exp_d[7-i]);
      end
      tick();
    end
    vectors++;
    if (status_out !== 8'h08) begin
      miscompares++;
      $display("FAIL rearm_done: got status=%h want 08", status_out);
    end
  endtask
  task automatic test_midframe;
    logic [7:0] exp_d;
    exp_d = 8'hC3;
    ctrl_in = 8'h00; tick();
    ctrl_in = 8'h21; data0_in = exp_d;
    tick(); tick();
    for (int i = 0; i < 24; i++) begin
      vectors++;
      if ({ser_valid, ser_out} !== {1'b1, exp_d[7-i/3]}) begin
        miscompares++;
        $display("FAIL midframe_cycle%0d: got valid/out=%b%b want 1%b", i, ser_valid, ser_out, exp_d[7-i/3]);
      end
      if (i == 5) ctrl_in = 8'h00;
      if (i == 6) ctrl_in = 8'h01;
      if (i == 8) begin
        ctrl_in = 8'h13;
        data0_in = 8'hFF;
        data1_in = 8'hFF;
      end
      tick();
    end
    vectors++;
    if (status_out !== 8'h08 || ser_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL midframe_done: got status=%h valid=%b want status=08 valid=0", status_out, ser_valid);
    end
  endtask
  task automatic test_reset_midframe;
    int seen_done;
    seen_done = 0;
    ctrl_in = 8'h00; tick();
    ctrl_in = 8'h01; data0_in = 8'hFF;
    tick(); tick();
    tick(); tick(); tick();
    vectors++;
    if ({ser_valid, ser_out} !== 2'b11) begin
      miscompares++;
      $display("FAIL rstmid_fourth_bit: got valid/out=%b%b want 11", ser_valid, ser_out);
    end
    rst = 1'b1;
    tick();
    vectors++;
    if (status_out !== 8'h00 || ser_valid !== 1'b0 || ser_out !== 1'b0) begin
      miscompares++;
      $display("FAIL rstmid_cleared: got status=%h valid=%b out=%b want 00 0 0", status_out, ser_valid, ser_out);
    end
    ctrl_in = 8'h00;
    tick();
    rst = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick();
      seen_done += int'(status_out[3]) + int'(ser_valid);
    end
    vectors++;
    if (seen_done != 0 || status_out !== 8'h00) begin
      miscompares++;
      $display("FAIL rstmid_no_done: got done/valid cycles=%0d status=%h want 0 and 00", seen_done, status_out);
    end
  endtask
  task automatic test_start_through_reset;
    rst = 1'b1; ctrl_in = 8'h01; data0_in = 8'h81;
    tick(); tick();
    rst = 1'b0;
    tick();
    vectors++;
    if (status_out !== 8'h04) begin
      miscompares++;
      $display("FAIL start_thru_reset_load: got status=%h want 04", status_out);
    end
    tick();
    vectors++;
    if ({ser_valid, ser_out} !== 2'b11) begin
      miscompares++;
      $display("FAIL start_thru_reset_first_bit: got valid/out=%b%b want 11", ser_valid, ser_out);
    end
    for (int i = 0; i < 8; i++) tick();
    vectors++;
    if (status_out !== 8'h08) begin
      miscompares++;
      $display("FAIL start_thru_reset_done: got status=%h want 08", status_out);
    end
  endtask
  task automatic test_max_div;
    logic [7:0] exp_d;
    exp_d = 8'h96;
    ctrl_in = 8'h00; tick();
    ctrl_in = 8'hF1; data0_in = exp_d;
    tick(); tick();
    ctrl_in = 8'h00;
    for (int i = 0; i < 128; i++) begin
      vectors++;
      if ({ser_valid, ser_out} !== {1'b1, exp_d[7-i/16]}) begin
        miscompares++;
        $display("FAIL maxdiv_cycle%0d: got valid/out=%b%b want 1%b", i, ser_valid, ser_out, exp_d[7-i/16]);
      end
      tick();
    end
    vectors++;
    if (status_out !== 8'h08 || ser_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL maxdiv_done: got status=%h valid=%b want status=08 valid=0", status_out, ser_valid);
    end
  endtask
  initial begin
    vectors = 0;
    miscompares = 0;
    test_reset();
    test_mode0();
    test_mode1_div();
    test_hold_rearm();
    test_midframe();
    test_reset_midframe();
    test_start_through_reset();
    test_max_div();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
